// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer capture read-out path.
package la_pkg;

  // Read-out states. The top sequences IDLE/FETCH/LATCH and uses START for
  // "word in flight". The byte transmitter walks START/DATA/STOP per frame.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } la_state_e;

  localparam int LA_WORD_BITS      = 32;
  localparam int LA_BYTES_PER_WORD = 4;
  localparam int UART_FRAME_BITS   = 10;

endpackage

// File: rtl/uart_byte_tx.sv
// UART 8N1 byte transmitter. i_start is accepted when idle or during the last
// cycle of a stop bit, so consecutive frames run back-to-back with no gap.
// o_done is high exactly during the last cycle of the stop bit, giving the
// caller one cycle to present the next byte together with i_start.
module uart_byte_tx
  import la_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       _mrst,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_tx,
  output logic       o_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

  la_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;

  // Frame FSM: bit-period counter, LSB-first shifter and registered line level.
  always_ff @(posedge i_clk or negedge _mrst) begin
    if (!_mrst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      o_tx    <= 1'b1;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        ST_START: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= ST_DATA;
            o_tx    <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit == 3'd7) begin
              r_state <= ST_STOP;
              o_tx    <= 1'b1;
            end else begin
              r_bit <= r_bit + 1'b1;
              o_tx  <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (i_start) begin
              r_shift <= i_byte;
              r_state <= ST_START;
              o_tx    <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              o_tx    <= 1'b1;
            end
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            o_done <= (r_cnt == CNT_PRE);
          end
        end
        default: begin
          o_tx <= 1'b1;
          if (i_start) begin
            r_shift <= i_byte;
            r_cnt   <= '0;
            r_state <= ST_START;
            o_tx    <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/capture_uart_reader.sv
// Drains the capture FIFO (normal, non-show-ahead read) and sends each 32-bit
// word as four big-endian UART bytes. Timing from the IDLE edge k that sees
// the fetch condition: rdreq high k..k+1, data latched at k+2, start bit
// after k+3, last stop bit ends at k+3+40*CLKS_PER_BIT.
module capture_uart_reader
  import la_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        i_clk,
  input  logic        _mrst,
  input  logic        i_enable,
  input  logic        i_empty,
  input  logic [31:0] i_data,
  output logic        o_rdreq,
  output logic        o_tx,
  output logic        o_busy,
  output logic [15:0] o_words_sent
);

  localparam logic [1:0] LAST_IDX = 2'(LA_BYTES_PER_WORD - 1);

  la_state_e               r_state;
  logic [LA_WORD_BITS-1:0] r_word;
  logic [1:0]              r_byte_idx;
  logic                    r_first;
  logic                    r_rdreq;
  logic                    r_busy;
  logic [15:0]             r_words_sent;

  logic       w_done;
  logic       w_start;
  logic       w_tx;
  logic [7:0] w_byte;

  // The word is shifted left as each byte is handed over, so the next byte
  // to send is always the top eight bits.
  assign w_byte  = r_word[LA_WORD_BITS-1 -: 8];
  assign w_start = r_first |
                   ((r_state == ST_START) && w_done && (r_byte_idx != LAST_IDX));

  assign o_rdreq      = r_rdreq;
  assign o_busy       = r_busy;
  assign o_words_sent = r_words_sent;
  assign o_tx         = w_tx;

  // Word-level FSM: fetch, latch, byte sequencing and the sent-word counter.
  always_ff @(posedge i_clk or negedge _mrst) begin
    if (!_mrst) begin
      r_state      <= ST_IDLE;
      r_word       <= '0;
      r_byte_idx   <= '0;
      r_first      <= 1'b0;
      r_rdreq      <= 1'b0;
      r_busy       <= 1'b0;
      r_words_sent <= '0;
    end else begin
      r_rdreq <= 1'b0;
      r_first <= 1'b0;
      if (w_start) begin
        r_word <= r_word << 8;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_enable && !i_empty) begin
            r_state <= ST_FETCH;
            r_rdreq <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_FETCH: begin
          r_state <= ST_LATCH;
        end
        ST_LATCH: begin
          r_word     <= i_data;
          r_byte_idx <= '0;
          r_first    <= 1'b1;
          r_state    <= ST_START;
        end
        ST_START: begin
          if (w_done) begin
            if (r_byte_idx == LAST_IDX) begin
              r_state      <= ST_IDLE;
              r_busy       <= 1'b0;
              r_words_sent <= r_words_sent + 16'd1;
            end else begin
              r_byte_idx <= r_byte_idx + 2'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .i_clk  (i_clk),
    ._mrst  (_mrst),
    .i_start(w_start),
    .i_byte (w_byte),
    .o_tx   (w_tx),
    .o_done (w_done)
  );

endmodule
